display_scan_ctrl: RTL and testbench



---
 rtl/display_pkg.sv | 27 ++
 rtl/display_scan_ctrl_if.sv | 26 ++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/display_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared display constants: widths and 7-segment patterns {a..g}, bit6 = a.
// Used by the hex decoder and the scan controller.
package display_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Frame/control inputs and pin outputs of the scan controller.
// master: frame source (drives enable/load/value/dp/blank/lz_en); slave: controller.
interface display_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic                      lz_en;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     digit_sel;
    logic                      pending;

    modport master (
        output enable, load, value_in, dp_in, blank_in, lz_en,
        input  seg_out, dp_out, digit_sel, pending
    );

    modport slave (
        input  enable, load, value_in, dp_in, blank_in, lz_en,
        output seg_out, dp_out, digit_sel, pending
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern {a..g}, active-high.
// Ports: nibble (4b in), seg (7b out).
module seg7_hex_decode
    import display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner with tear-free shadow frame load.
// Ports: clk, rst_n (async low), bus (slave: frame in, seg/dp/digit_sel/pending out).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    display_scan_ctrl_if.slave bus
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = NIBBLE_W * NUM_DIGITS;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic [VW-1:0]         act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
    logic [VW-1:0]         shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0] shd_blank_q, shd_blank_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dpo_q, dpo_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;

    logic                  tick, boundary;
    logic [NIBBLE_W-1:0]   cur_nib;
    logic                  cur_dp, cur_blank, cur_supp;
    logic [NUM_DIGITS-1:0] supp;
    logic                  lz_run;
    logic [SEG_W-1:0]      dec_seg;

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Scan timing and shadow/active frame handling
    always_comb begin
        tick     = bus.enable && (presc_q == PRE_LAST);
        boundary = tick && (idx_q == IDX_LAST);

        presc_d = presc_q;
        idx_d   = idx_q;
        if (bus.enable) presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick)       idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        pending_d   = pending_q;
        shd_val_d   = shd_val_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;

        if (bus.load) begin
            shd_val_d   = bus.value_in;
            shd_dp_d    = bus.dp_in;
            shd_blank_d = bus.blank_in;
            pending_d   = 1'b1;
        end

        // A load landing on the boundary bypasses the shadow
        if (boundary) begin
            if (bus.load) begin
                act_val_d   = bus.value_in;
                act_dp_d    = bus.dp_in;
                act_blank_d = bus.blank_in;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                act_val_d   = shd_val_q;
                act_dp_d    = shd_dp_q;
                act_blank_d = shd_blank_q;
                pending_d   = 1'b0;
            end
        end
    end

    // Leading-zero run from the top digit down; digit 0 always shown
    always_comb begin
        lz_run = bus.lz_en;
        supp   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_run  = lz_run
                   && (act_val_q[k*NIBBLE_W +: NIBBLE_W] == '0)
                   && !act_dp_q[k];
            supp[k] = lz_run && (k != 0);
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_supp  = 1'b0;
        sel_d     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = act_val_q[k*NIBBLE_W +: NIBBLE_W];
                cur_dp    = act_dp_q[k];
                cur_blank = act_blank_q[k];
                cur_supp  = supp[k];
                sel_d[k]  = bus.enable;
            end
        end

        seg_d = SEG_BLANK;
        dpo_d = 1'b0;
        if (bus.enable && !cur_blank && !cur_supp) begin
            seg_d = dec_seg;
            dpo_d = cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
            shd_val_q   <= '0;
            shd_dp_q    <= '0;
            shd_blank_q <= '1;
            seg_q       <= SEG_BLANK;
            dpo_q       <= 1'b0;
            sel_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            act_val_q   <= act_val_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            shd_val_q   <= shd_val_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
            seg_q       <= seg_d;
            dpo_q       <= dpo_d;
            sel_q       <= sel_d;
        end
    end

    // Pin polarity applied after the output registers
    assign bus.seg_out   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign bus.dp_out    = SEG_ACTIVE_LOW ? ~dpo_q : dpo_q;
    assign bus.digit_sel = AN_ACTIVE_LOW  ? ~sel_q : sel_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: 4 digits, CLK_DIV=4, active-high pins.
// Frame vectors from a table plus hand-written timing corner sequences.
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    display_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    display_scan_ctrl #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (4),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            lz;
        logic [3:0][6:0] seg;
        logic [3:0]      edp;
    } vec_t;

    exp_t q[$];
    vec_t vt[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout, sel=%b pending=%b", name,
                 bus.digit_sel, bus.pending);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Wait for the first negedge on which digit_sel becomes m
    task automatic wait_edge(input logic [3:0] m);
        int i;
        for (i = 0; i < 40 && bus.digit_sel === m; i++) step();
        for (i = 0; i < 40 && bus.digit_sel !== m; i++) step();
        if (bus.digit_sel !== m) timeout("wait_edge");
    endtask

    task automatic wait_pend0();
        int i;
        for (i = 0; i < 40 && bus.pending !== 1'b0; i++) step();
        if (bus.pending !== 1'b0) timeout("wait_pend0");
    endtask

    task automatic push_slot(input logic [3:0] s, input logic [6:0] g,
                             input logic d);
        exp_t e;
        e.sel = s;
        e.seg = g;
        e.dp  = d;
        q.push_back(e);
    endtask

    task automatic push_frame(input vec_t v);
        for (int k = 0; k < 4; k++)
            push_slot(4'b0001 << k, v.seg[k], v.edp[k]);
    endtask

    // One expectation per digit slot, checked at the slot's first cycle
    task automatic drain_slots(input string name);
        exp_t e;
        int   i;
        while (q.size() > 0) begin
            e = q.pop_front();
            for (i = 0; i < 20 && bus.digit_sel !== e.sel; i++) step();
            if (bus.digit_sel !== e.sel) begin
                timeout(name);
            end else begin
                chk({name, "_seg"}, 32'(bus.seg_out), 32'(e.seg));
                chk({name, "_dp"}, 32'(bus.dp_out), 32'(e.dp));
            end
        end
    endtask

    // One expectation per clock, checked at consecutive negedges
    task automatic drain_cycles(input string name);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({name, "_sel"}, 32'(bus.digit_sel), 32'(e.sel));
            chk({name, "_seg"}, 32'(bus.seg_out), 32'(e.seg));
            chk({name, "_dp"}, 32'(bus.dp_out), 32'(e.dp));
            step();
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] b, input logic lz);
        bus.value_in = v;
        bus.dp_in    = d;
        bus.blank_in = b;
        bus.lz_en    = lz;
        bus.load     = 1'b1;
    endtask

    initial begin
        vt[0] = '{16'h12AF, 4'b0100, 4'b0000, 1'b0,
                  {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}, 4'b0100};
        vt[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, 4'b0000};
        vt[2] = '{16'h0050, 4'b1000, 4'b0000, 1'b1,
                  {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110}, 4'b1000};
        vt[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000};
        vt[4] = '{16'h8888, 4'b1111, 4'b0101, 1'b0,
                  {7'b1111111, 7'b0000000, 7'b1111111, 7'b0000000}, 4'b1010};
        vt[5] = '{16'hCDE9, 4'b0001, 4'b0000, 1'b1,
                  {7'b1001110, 7'b0111101, 7'b1001111, 7'b1111011}, 4'b0001};
        vt[6] = '{16'h0407, 4'b0000, 4'b0000, 1'b1,
                  {7'b0000000, 7'b0110011, 7'b1111110, 7'b1110000}, 4'b0000};
        vt[7] = '{16'h6B30, 4'b0000, 4'b0000, 1'b0,
                  {7'b1011111, 7'b0011111, 7'b1111001, 7'b1111110}, 4'b0000};

        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        bus.lz_en    = 1'b0;
        step();
        step();
        chk("rst_sel", 32'(bus.digit_sel), 32'h0);
        chk("rst_seg", 32'(bus.seg_out), 32'h0);
        chk("rst_dp", 32'(bus.dp_out), 32'h0);
        chk("rst_pend", 32'(bus.pending), 32'h0);

        // Free-running walk, 4 clocks per digit, all blank
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                push_slot(4'b0001 << k, 7'b0, 1'b0);
        step();
        drain_cycles("walk");

        // Table of frames
        for (int v = 0; v < 8; v++) begin
            wait_edge(4'b0010);
            drive(vt[v].val, vt[v].dp, vt[v].blank, vt[v].lz);
            step();
            bus.load = 1'b0;
            chk("vec_pend_set", 32'(bus.pending), 32'h1);
            wait_pend0();
            push_frame(vt[v]);
            drain_slots($sformatf("vec%0d", v));
        end

        // Two loads in one frame: last one wins
        wait_edge(4'b0010);
        drive(16'h1111, 4'b0, 4'b0, 1'b0);
        step();
        bus.load = 1'b0;
        step();
        drive(16'h2222, 4'b0, 4'b0, 1'b0);
        step();
        bus.load = 1'b0;
        chk("dbl_pend", 32'(bus.pending), 32'h1);
        wait_pend0();
        for (int k = 0; k < 4; k++)
            push_slot(4'b0001 << k, 7'b1101101, 1'b0);
        drain_slots("dbl");

        // Load on the boundary cycle goes straight to the display
        wait_edge(4'b1000);
        step();
        step();
        drive(16'h4567, 4'b0, 4'b0, 1'b0);
        step();
        bus.load = 1'b0;
        chk("bnd_pend", 32'(bus.pending), 32'h0);
        push_slot(4'b0001, 7'b1110000, 1'b0);
        push_slot(4'b0010, 7'b1011111, 1'b0);
        push_slot(4'b0100, 7'b1011011, 1'b0);
        push_slot(4'b1000, 7'b0110011, 1'b0);
        drain_slots("bnd");
        chk("bnd_pend2", 32'(bus.pending), 32'h0);

        // Enable dropped mid-slot at index 2, load taken while dark
        wait_edge(4'b0100);
        step();
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("dark_sel", 32'(bus.digit_sel), 32'h0);
            chk("dark_seg", 32'(bus.seg_out), 32'h0);
            chk("dark_dp", 32'(bus.dp_out), 32'h0);
            if (i == 3) drive(16'h9999, 4'b0, 4'b0, 1'b0);
            if (i == 4) bus.load = 1'b0;
        end
        chk("dark_pend", 32'(bus.pending), 32'h1);
        bus.enable = 1'b1;
        push_slot(4'b0100, 7'b1011011, 1'b0);
        push_slot(4'b0100, 7'b1011011, 1'b0);
        push_slot(4'b1000, 7'b0110011, 1'b0);
        step();
        drain_cycles("resume");
        wait_pend0();
        for (int k = 0; k < 4; k++)
            push_slot(4'b0001 << k, 7'b1111011, 1'b0);
        drain_slots("resume_frame");

        // Async reset mid-frame with a pending shadow
        wait_edge(4'b0010);
        drive(16'h1234, 4'b0, 4'b0, 1'b0);
        step();
        bus.load = 1'b0;
        chk("rst2_pend_set", 32'(bus.pending), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_sel", 32'(bus.digit_sel), 32'h0);
        chk("rst2_seg", 32'(bus.seg_out), 32'h0);
        chk("rst2_pend", 32'(bus.pending), 32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++)
            push_slot(4'b0001, 7'b0, 1'b0);
        step();
        drain_cycles("rst2_walk");
        push_slot(4'b0010, 7'b0, 1'b0);
        push_slot(4'b0100, 7'b0, 1'b0);
        push_slot(4'b1000, 7'b0, 1'b0);
        push_slot(4'b0001, 7'b0, 1'b0);
        push_slot(4'b0010, 7'b0, 1'b0);
        drain_slots("rst2_blank");
        chk("rst2_pend_end", 32'(bus.pending), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
